cmd_proc_regs: RTL and testbench
================================

// Module: cmd_proc_regs
// PURPOSE
//  Consumes 16-bit commands from the UART command wrapper (cmd/cmd_rdy) and executes them on a small 8-bit register file.
//  Returns exactly one 8-bit response byte per command through the wrapper's transmit side (send_resp/resp/resp_sent).
//  Sits directly downstream of the UART wrapper; register outputs feed the datapath.
// PARAMETERS
//  NUM_REGS    8     number of 8-bit registers (2..16); valid addr range 0..NUM_REGS-1
//  ACK_BYTE    8'hA5 response for a successful WRITE or CLEAR
//  ERR_BYTE    8'hEE response for a bad opcode or an out-of-range address
//  RESP_TMO    1023  resp_sent timeout in clk cycles (used only with the macro)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  rst          in   1           synchronous, active-high reset
//  cmd          in   16          command from wrapper; valid only in the cycle cmd_rdy is seen
//  cmd_rdy      in   1           wrapper holds high until cleared
//  clr_cmd_rdy  out  1           1-cycle pulse that consumes the command
//  send_resp    out  1           1-cycle pulse that starts a response byte
//  resp         out  8           response byte, stable from send_resp until resp_sent
//  resp_sent    in   1           1-cycle pulse when the byte has fully shifted out
//  busy         out  1           high in every state except IDLE
//  regs_out     out  8*NUM_REGS  flattened register file; reg i = [8i+7:8i]
//  resp_tmo_err out  1           sticky response-timeout flag
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - state=IDLE; every register = 0; resp = 8'h00; resp_tmo_err = 0.
//   - clr_cmd_rdy, send_resp, busy all 0.
//   - Reset mid-operation aborts the command; no response is sent.
//  Command format:
//   - op = cmd[15:12], addr = cmd[11:8], data = cmd[7:0].
//   - op 4'h1 WRITE: reg[addr] <= data; resp = ACK_BYTE.
//   - op 4'h2 READ: resp = reg[addr].
//   - op 4'h3 CLEAR: all regs <= 0; resp = ACK_BYTE; addr ignored.
//   - any other op, or addr >= NUM_REGS on WRITE/READ: no register change; resp = ERR_BYTE.
//  FSM states: IDLE, EXEC, SEND, WAIT_DONE.
//   - IDLE: when cmd_rdy=1, clr_cmd_rdy=1 the same cycle (combinational), cmd latched into cmd_q, next=EXEC.
//   - EXEC: register update and resp computed from cmd_q, resp registered; next=SEND.
//   - SEND: send_resp=1 for exactly one cycle; next=WAIT_DONE.
//   - WAIT_DONE: resp_sent=1 -> IDLE. Otherwise stay.
//  Latency: cmd_rdy seen at cycle N -> register write visible on regs_out at N+2; send_resp at N+2.
//  cmd_rdy while busy: ignored. The wrapper keeps it pending; the command is taken in the first IDLE cycle.
//  Back-to-back commands: one IDLE cycle minimum between resp_sent and the next clr_cmd_rdy.
//  resp_sent outside WAIT_DONE: ignored.
//  READ of a register written by the previous command returns the new value.
// CONFIGURATION
//  Macro CMD_PROC_RESP_TIMEOUT_EN:
//   - Defined: a counter clears on entry to WAIT_DONE. If it reaches RESP_TMO without resp_sent, the FSM goes to IDLE
//     and sets resp_tmo_err. The flag stays set until rst or the next accepted cmd.
//   - Undefined: there is no counter; WAIT_DONE waits indefinitely; resp_tmo_err is tied 0. The port list is unchanged.
// STRUCTURE
//  Package cmd_proc_pkg holds:
//   - typedef enum logic [3:0] op_t {OP_WRITE=1, OP_READ=2, OP_CLEAR=3}
//   - typedef enum logic [1:0] state_t
//   - localparams ACK_DEF=8'hA5, ERR_DEF=8'hEE
//  Sub-module resp_timer (only under the macro): counter with start/expire, width $clog2(RESP_TMO+1).
//  The register file, decode and FSM stay in this module.
// TESTING
//  1. WRITE: cmd=16'h1342 with cmd_rdy -> clr_cmd_rdy in the same cycle; regs_out[31:24]=8'h42 two cycles later;
//     send_resp pulse with resp=8'hA5; busy drops one cycle after resp_sent.
//  2. READ: after test 1, cmd=16'h2300 -> resp=8'h42.
//  3. Error: cmd=16'h2900 (addr 9 >= 8) -> resp=8'hEE, no reg changes; cmd=16'h7000 -> resp=8'hEE.
//  4. CLEAR and busy: cmd=16'h3000 -> all regs 0, resp=8'hA5.
//     Hold a second cmd_rdy during WAIT_DONE -> no clr_cmd_rdy until IDLE, then accepted.
//  5. Reset: rst in WAIT_DONE -> next cycle busy=0, send_resp=0, regs 0, resp=8'h00; later resp_sent is ignored.
//  6. Timeout (macro on, RESP_TMO=15): resp_sent withheld -> IDLE after 15 cycles, resp_tmo_err=1;
//     the next accepted cmd clears the flag. With the macro off, it stays in WAIT_DONE and the flag stays 0.

Source files
------------

// File: rtl/cmd_proc_pkg.sv
// Shared types and constants for the command processor and its register file.
package cmd_proc_pkg;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_CLEAR = 4'h3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] ERR_DEF = 8'hEE;

  // True when a 4-bit command address selects an implemented register.
  function automatic logic addr_in_range(input logic [3:0] addr, input int num_regs);
    return int'({28'd0, addr}) < num_regs;
  endfunction

endpackage

// File: rtl/cmd_proc_regs_resp_timer.sv
// Response timeout down-counter: loaded with RESP_TMO on start, counts down
// while run is high, expire flags the last allowed waiting cycle.
// Only instantiated when CMD_PROC_RESP_TIMEOUT_EN is defined.
module resp_timer #(
  parameter int RESP_TMO = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int W = $clog2(RESP_TMO + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Load on start, decrement while waiting, hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = W'(RESP_TMO);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: this is the RESP_TMO-th cycle spent waiting.
  assign expire_o = run_i && (cnt_q == W'(1));

endmodule

// File: rtl/cmd_proc_regs.sv
// Command processor: takes 16-bit commands from the UART wrapper, executes
// them on an 8-bit register file and returns one response byte per command.
// Optional response timeout enabled by defining CMD_PROC_RESP_TIMEOUT_EN.
//
//  state        | meaning
//  ST_IDLE      | waiting for cmd_rdy; consumes and latches the command
//  ST_EXEC      | decode cmd_q, update registers, register the response
//  ST_SEND      | one-cycle send_resp pulse
//  ST_WAIT_DONE | wait for resp_sent (or timeout when enabled)
module cmd_proc_regs
  import cmd_proc_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [7:0]  ACK_BYTE = ACK_DEF,
  parameter logic [7:0]  ERR_BYTE = ERR_DEF,
  parameter int          RESP_TMO = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cmd,
  input  logic                  cmd_rdy,
  output logic                  clr_cmd_rdy,
  output logic                  send_resp,
  output logic [7:0]            resp,
  input  logic                  resp_sent,
  output logic                  busy,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  resp_tmo_err
);

  state_t      state_q, state_d;
  logic [15:0] cmd_q;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic [7:0]  resp_q, resp_d;
  logic        tmo_err_q, tmo_err_d;

  logic [3:0]  op;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        addr_ok;
  logic [7:0]  rd_val;
  logic        tmr_start;
  logic        tmr_run;
  logic        tmo_expire;

  assign op      = cmd_q[15:12];
  assign addr    = cmd_q[11:8];
  assign data    = cmd_q[7:0];
  assign addr_ok = addr_in_range(addr, NUM_REGS);

`ifdef CMD_PROC_RESP_TIMEOUT_EN
  resp_timer #(
    .RESP_TMO (RESP_TMO)
  ) u_resp_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (tmr_start),
    .run_i    (tmr_run),
    .expire_o (tmo_expire)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{tmr_start, tmr_run, RESP_TMO};
  assign tmo_expire     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; resp_sent wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cmd_rdy) state_d = ST_EXEC;
      ST_EXEC:      state_d = ST_SEND;
      ST_SEND:      state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (resp_sent || tmo_expire) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; command consumption is suppressed while reset is applied.
  always_comb begin
    clr_cmd_rdy = (state_q == ST_IDLE) && cmd_rdy && !rst;
    send_resp   = (state_q == ST_SEND);
    busy        = (state_q != ST_IDLE);
    tmr_start   = (state_q == ST_SEND);
    tmr_run     = (state_q == ST_WAIT_DONE);
  end

  // Read mux over the register file.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 4'(i)) rd_val = regs_q[i];
    end
  end

  // Command execution: register updates and response byte, only in EXEC.
  always_comb begin
    regs_d = regs_q;
    resp_d = resp_q;
    if (state_q == ST_EXEC) begin
      case (op)
        OP_WRITE: begin
          if (addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr == 4'(i)) regs_d[i] = data;
            end
            resp_d = ACK_BYTE;
          end else begin
            resp_d = ERR_BYTE;
          end
        end
        OP_READ:  resp_d = addr_ok ? rd_val : ERR_BYTE;
        OP_CLEAR: begin
          for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
          resp_d = ACK_BYTE;
        end
        default:  resp_d = ERR_BYTE;
      endcase
    end
  end

  // Timeout flag: set on timeout exit, cleared when a new command is taken.
  always_comb begin
    tmo_err_d = tmo_err_q;
    if (clr_cmd_rdy) begin
      tmo_err_d = 1'b0;
    end else if ((state_q == ST_WAIT_DONE) && !resp_sent && tmo_expire) begin
      tmo_err_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      resp_q    <= '0;
      tmo_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (clr_cmd_rdy) cmd_q <= cmd;
      resp_q    <= resp_d;
      tmo_err_q <= tmo_err_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Flatten the register file for the datapath.
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_out[8*i +: 8] = regs_q[i];
  end

  assign resp         = resp_q;
  assign resp_tmo_err = tmo_err_q;

endmodule

// File: tb/tb_cmd_proc_regs.sv
// Self-checking bench for cmd_proc_regs: directed scenarios followed by random
// commands checked against a register-file reference model.
module tb_cmd_proc_regs;

  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic          send_resp;
  logic [7:0]    resp;
  logic          resp_sent;
  logic          busy;
  logic [8*NR-1:0] regs_out;
  logic          resp_tmo_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_regs [NR];
  logic [7:0] exp_resp;

  always #5 clk = ~clk;

  cmd_proc_regs #(
    .NUM_REGS (NR),
    .RESP_TMO (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .resp_sent    (resp_sent),
    .busy         (busy),
    .regs_out     (regs_out),
    .resp_tmo_err (resp_tmo_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] m_flat();
    logic [63:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  // Reference: what a command does to the register file and what it answers.
  function automatic logic [7:0] m_exec(input logic [15:0] c);
    int op, a;
    op = int'(c[15:12]);
    a  = int'(c[11:8]);
    if (op == 1 && a < NR) begin
      m_regs[a] = c[7:0];
      return 8'hA5;
    end
    if (op == 2 && a < NR) return m_regs[a];
    if (op == 3) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      return 8'hA5;
    end
    return 8'hEE;
  endfunction

  // Present a command, wait for it to be consumed, check up to WAIT_DONE.
  task automatic issue(input logic [15:0] c);
    int n;
    cmd     = c;
    cmd_rdy = 1'b1;
    #1;
    n = 0;
    while (!clr_cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", clr_cmd_rdy, 1);
    exp_resp = m_exec(c);
    @(posedge clk);
    #1;
    cmd_rdy = 1'b0;
    cmd     = 16'($urandom);
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_nosend", send_resp, 0);
    @(negedge clk);
    chk("send_pulse", send_resp, 1);
    chk("send_resp_val", resp, exp_resp);
    chk("regs_at_send", regs_out, m_flat());
    chk("tmo_flag_clear", resp_tmo_err, 0);
    @(negedge clk);
    chk("send_one_cycle", send_resp, 0);
  endtask

  // Pulse resp_sent and check the FSM returns to IDLE one cycle later.
  task automatic finish();
    @(posedge clk);
    #1;
    resp_sent = 1'b1;
    @(negedge clk);
    chk("wait_busy", busy, 1);
    chk("resp_stable", resp, exp_resp);
    @(posedge clk);
    #1;
    resp_sent = 1'b0;
    @(negedge clk);
    chk("idle_after_sent", busy, 0);
  endtask

  initial begin
    logic [15:0] c;
    int sel, a;
    rst       = 1'b1;
    cmd       = 16'h0000;
    cmd_rdy   = 1'b0;
    resp_sent = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    exp_resp = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_send", send_resp, 0);
    chk("rst_clr", clr_cmd_rdy, 0);
    chk("rst_regs", regs_out, 0);
    chk("rst_resp", resp, 0);
    chk("rst_tmo", resp_tmo_err, 0);

    // WRITE then READ back.
    issue(16'h1342);
    chk("reg3_written", regs_out[31:24], 8'h42);
    chk("write_ack", resp, 8'hA5);
    finish();
    issue(16'h2300);
    chk("read_back", resp, 8'h42);
    finish();

    // Error responses.
    issue(16'h2900);
    chk("bad_addr", resp, 8'hEE);
    finish();
    issue(16'h1855);
    chk("bad_addr_wr", resp, 8'hEE);
    finish();
    issue(16'h7000);
    chk("bad_op", resp, 8'hEE);
    finish();

    // CLEAR with a second command held pending through WAIT_DONE.
    issue(16'h1777);
    finish();
    issue(16'h3000);
    chk("clear_regs", regs_out, 0);
    chk("clear_ack", resp, 8'hA5);
    cmd     = 16'h1705;
    cmd_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pending_ignored", clr_cmd_rdy, 0);
    end
    finish();
    chk("pending_taken", clr_cmd_rdy, 1);
    issue(16'h1705);
    finish();

    // resp_sent while idle does nothing.
    @(posedge clk);
    #1;
    resp_sent = 1'b1;
    @(posedge clk);
    #1;
    resp_sent = 1'b0;
    @(negedge clk);
    chk("stray_sent_busy", busy, 0);
    chk("stray_sent_send", send_resp, 0);

    // Reset in WAIT_DONE aborts the command.
    issue(16'h1299);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_send", send_resp, 0);
    chk("midrst_regs", regs_out, 0);
    chk("midrst_resp", resp, 0);
    @(posedge clk);
    #1;
    resp_sent = 1'b1;
    @(posedge clk);
    #1;
    resp_sent = 1'b0;
    @(negedge clk);
    chk("postrst_sent_busy", busy, 0);
    chk("postrst_sent_send", send_resp, 0);

    // Response timeout.
    issue(16'h1011);
`ifdef CMD_PROC_RESP_TIMEOUT_EN
    repeat (14) @(negedge clk);
    chk("tmo_last_wait", busy, 1);
    chk("tmo_not_yet", resp_tmo_err, 0);
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_flag_set", resp_tmo_err, 1);
    issue(16'h2000);
    chk("tmo_next_read", resp, 8'h11);
    finish();
`else
    repeat (20) @(negedge clk);
    chk("notmo_still_wait", busy, 1);
    chk("notmo_flag", resp_tmo_err, 0);
    finish();
`endif

    // Random commands against the model.
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NR - 1));
      c[11:8] = 4'(a);
      c[7:0]  = 8'($urandom);
      if (sel < 4)       c[15:12] = 4'h1;
      else if (sel < 7)  c[15:12] = 4'h2;
      else if (sel == 7) c[15:12] = 4'h3;
      else               c[15:12] = 4'($urandom_range(4, 15));
      issue(c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
